// File: rtl/mult_pkg.sv
// Shared types and default widths for the shift-add multiplier (controller and shifter).
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TEST,
        ADD,
        SHIFT,
        DONE
    } mult_state_t;

    localparam int DEF_N      = 8;
    localparam int DEF_M      = 8;
    localparam int DEF_PROD_W = DEF_N + DEF_M;

    function automatic logic is_busy(input mult_state_t s);
        return (s == LOAD) || (s == TEST) || (s == ADD) || (s == SHIFT);
    endfunction

endpackage

// File: rtl/mult_iter_cnt.sv
// Iteration counter for the multiplier controller; flags the final shift (count == n-1).
module mult_iter_cnt
    import mult_pkg::*;
#(
    parameter int n     = DEF_N,
    parameter int CNT_W = $clog2(n)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(n - 1);

    logic [CNT_W-1:0] count;

    // Holding at n-1 keeps the counter from ever wrapping.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && !last) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == LAST_VAL);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Control FSM for the shift-add multiplier: sequences load, optional add, and n shifts,
// then holds out_cmd until the next operation.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int n     = DEF_N,
    parameter int CNT_W = $clog2(n)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic lsb,
    output logic load_cmd,
    output logic add_cmd,
    output logic shift_cmd,
    output logic out_cmd,
    output logic busy,
    output logic done
);

    mult_state_t state;
    mult_state_t state_nxt;
    logic        last;

    mult_iter_cnt #(
        .n    (n),
        .CNT_W(CNT_W)
    ) u_iter_cnt (
        .clk  (clk),
        .rst  (rst),
        .clear(state == LOAD),
        .inc  (state == SHIFT),
        .last (last)
    );

    // TEST waits a cycle so lsb reflects the most recent load or shift.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = TEST;
            TEST:    state_nxt = lsb ? ADD : SHIFT;
            ADD:     state_nxt = SHIFT;
            SHIFT:   state_nxt = last ? DONE : TEST;
            DONE:    if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            load_cmd  <= 1'b0;
            add_cmd   <= 1'b0;
            shift_cmd <= 1'b0;
            out_cmd   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            load_cmd  <= (state_nxt == LOAD);
            add_cmd   <= (state_nxt == ADD);
            shift_cmd <= (state_nxt == SHIFT);
            out_cmd   <= (state_nxt == DONE);
            busy      <= is_busy(state_nxt);
            done      <= (state_nxt == DONE) && (state != DONE);
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with n=8 and n=4 instances, each driving a behavioural
// shift-add datapath so the product can be checked alongside cycle counts.
module tb_mult_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start8 = 1'b0;
    logic start4 = 1'b0;

    logic ld8, ad8, sh8, oc8, busy8, done8, lsb8;
    logic ld4, ad4, sh4, oc4, busy4, done4, lsb4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.n(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start8),
        .lsb      (lsb8),
        .load_cmd (ld8),
        .add_cmd  (ad8),
        .shift_cmd(sh8),
        .out_cmd  (oc8),
        .busy     (busy8),
        .done     (done8)
    );

    mult_seq_ctrl #(.n(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .start    (start4),
        .lsb      (lsb4),
        .load_cmd (ld4),
        .add_cmd  (ad4),
        .shift_cmd(sh4),
        .out_cmd  (oc4),
        .busy     (busy4),
        .done     (done4)
    );

    // Behavioural shifters: {carry, upper, lower}, add-before-shift when armed.
    logic [7:0]  a8 = 8'h00, q8 = 8'h00;
    logic [16:0] work8;
    logic        flag8;
    logic [8:0]  sum8;
    assign sum8 = {1'b0, work8[15:8]} + (flag8 ? {1'b0, a8} : 9'd0);
    assign lsb8 = work8[0];

    always @(posedge clk) begin
        if (rst) begin
            work8 <= '0;
            flag8 <= 1'b0;
        end else if (ld8) begin
            work8 <= {9'd0, q8};
            flag8 <= 1'b0;
        end else if (sh8) begin
            work8 <= {1'b0, sum8, work8[7:1]};
            flag8 <= 1'b0;
        end else if (ad8) begin
            flag8 <= 1'b1;
        end
    end

    logic [3:0] a4 = 4'h0, q4 = 4'h0;
    logic [8:0] work4;
    logic       flag4;
    logic [4:0] sum4;
    assign sum4 = {1'b0, work4[7:4]} + (flag4 ? {1'b0, a4} : 5'd0);
    assign lsb4 = work4[0];

    always @(posedge clk) begin
        if (rst) begin
            work4 <= '0;
            flag4 <= 1'b0;
        end else if (ld4) begin
            work4 <= {5'd0, q4};
            flag4 <= 1'b0;
        end else if (sh4) begin
            work4 <= {1'b0, sum4, work4[3:1]};
            flag4 <= 1'b0;
        end else if (ad4) begin
            flag4 <= 1'b1;
        end
    end

    // Runs one operation on the selected instance and tallies what the controller did.
    task automatic run_op(input bit sel, input logic [7:0] q, input bit spam,
                          output int done_cyc, output int load_cyc, output int adds,
                          output int shifts, output int excl_err, output int pair_err,
                          output logic [7:0] add_mask, output logic oc_at1);
        logic l, a, s, o, b, d;
        bit prev_add;
        done_cyc = -1; load_cyc = -1; adds = 0; shifts = 0;
        excl_err = 0; pair_err = 0; add_mask = 8'h00; oc_at1 = 1'bx; prev_add = 0;
        @(negedge clk);
        if (sel) begin q4 = q[3:0]; start4 = 1'b1; end
        else     begin q8 = q;      start8 = 1'b1; end
        @(posedge clk);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            l = sel ? ld4 : ld8;   a = sel ? ad4 : ad8;   s = sel ? sh4 : sh8;
            o = sel ? oc4 : oc8;   b = sel ? busy4 : busy8; d = sel ? done4 : done8;
            if (cyc == 1) oc_at1 = o;
            if (l && load_cyc < 0) load_cyc = cyc;
            if (a) begin
                adds++;
                if (shifts < 8) add_mask[shifts] = 1'b1;
            end
            if (s) shifts++;
            if (int'(l) + int'(a) + int'(s) + int'(o) > 1) excl_err++;
            if (prev_add && !s) pair_err++;
            prev_add = a;
            if (d) begin
                done_cyc = cyc;
                break;
            end
            if (sel) start4 = spam && b;
            else     start8 = spam && b;
        end
        start8 = 1'b0;
        start4 = 1'b0;
    endtask

    int dc, lc, na, ns, ee, pe;
    logic [7:0] am;
    logic oc1;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({ld8, ad8, sh8, oc8, busy8, done8} !== 6'b0) begin errors++; $display("[TB] FAIL reset_outputs_n8: got %b expected 000000", {ld8, ad8, sh8, oc8, busy8, done8}); end
        checks++; if ({ld4, ad4, sh4, oc4, busy4, done4} !== 6'b0) begin errors++; $display("[TB] FAIL reset_outputs_n4: got %b expected 000000", {ld4, ad4, sh4, oc4, busy4, done4}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({ld8, busy8, oc8} !== 3'b0) begin errors++; $display("[TB] FAIL idle_hold: got %b expected 000", {ld8, busy8, oc8}); end
    endtask

    task automatic test_zero();
        a8 = 8'h3C;
        run_op(1'b0, 8'h00, 1'b0, dc, lc, na, ns, ee, pe, am, oc1);
        checks++; if (lc !== 1)  begin errors++; $display("[TB] FAIL zero_load_cycle: got %0d expected 1", lc); end
        checks++; if (dc !== 18) begin errors++; $display("[TB] FAIL zero_done_cycle: got %0d expected 18", dc); end
        checks++; if (ns !== 8)  begin errors++; $display("[TB] FAIL zero_shifts: got %0d expected 8", ns); end
        checks++; if (na !== 0)  begin errors++; $display("[TB] FAIL zero_adds: got %0d expected 0", na); end
        checks++; if (work8[15:0] !== 16'h0000) begin errors++; $display("[TB] FAIL zero_product: got %h expected 0000", work8[15:0]); end
        repeat (3) @(negedge clk);
        checks++; if ({oc8, done8, busy8} !== 3'b100) begin errors++; $display("[TB] FAIL zero_out_hold: got %b expected 100", {oc8, done8, busy8}); end
    endtask

    task automatic test_a5();
        a8 = 8'h3C;
        run_op(1'b0, 8'hA5, 1'b0, dc, lc, na, ns, ee, pe, am, oc1);
        checks++; if (dc !== 22)    begin errors++; $display("[TB] FAIL a5_done_cycle: got %0d expected 22", dc); end
        checks++; if (na !== 4)     begin errors++; $display("[TB] FAIL a5_adds: got %0d expected 4", na); end
        checks++; if (am !== 8'hA5) begin errors++; $display("[TB] FAIL a5_add_positions: got %h expected a5", am); end
        checks++; if (pe !== 0)     begin errors++; $display("[TB] FAIL a5_add_then_shift: got %0d expected 0", pe); end
        checks++; if (work8[15:0] !== 16'h26AC) begin errors++; $display("[TB] FAIL a5_product: got %h expected 26ac", work8[15:0]); end
    endtask

    task automatic test_ff();
        a8 = 8'hFF;
        run_op(1'b0, 8'hFF, 1'b0, dc, lc, na, ns, ee, pe, am, oc1);
        checks++; if (dc !== 26) begin errors++; $display("[TB] FAIL ff_done_cycle: got %0d expected 26", dc); end
        checks++; if (na !== 8)  begin errors++; $display("[TB] FAIL ff_adds: got %0d expected 8", na); end
        checks++; if (ee !== 0)  begin errors++; $display("[TB] FAIL ff_exclusive: got %0d expected 0", ee); end
        checks++; if (work8[15:0] !== 16'hFE01) begin errors++; $display("[TB] FAIL ff_product: got %h expected fe01", work8[15:0]); end
    endtask

    task automatic test_busy_start();
        a8 = 8'h3C;
        run_op(1'b0, 8'hA5, 1'b1, dc, lc, na, ns, ee, pe, am, oc1);
        checks++; if (dc !== 22) begin errors++; $display("[TB] FAIL busy_done_cycle: got %0d expected 22", dc); end
        checks++; if (ns !== 8)  begin errors++; $display("[TB] FAIL busy_shifts: got %0d expected 8", ns); end
        checks++; if (na !== 4)  begin errors++; $display("[TB] FAIL busy_adds: got %0d expected 4", na); end
        checks++; if (work8[15:0] !== 16'h26AC) begin errors++; $display("[TB] FAIL busy_product: got %h expected 26ac", work8[15:0]); end
    endtask

    task automatic test_reset_mid();
        int add_seen;
        bit hit;
        add_seen = 0;
        hit = 0;
        a8 = 8'hFF;
        @(negedge clk);
        q8 = 8'hFF;
        start8 = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (ad8) add_seen++;
            if (add_seen == 3) begin
                hit = 1;
                break;
            end
        end
        checks++; if (!hit) begin errors++; $display("[TB] FAIL mid_reach_add3: got %0d adds expected 3", add_seen); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({ld8, ad8, sh8, oc8, busy8, done8} !== 6'b0) begin errors++; $display("[TB] FAIL mid_reset_outputs: got %b expected 000000", {ld8, ad8, sh8, oc8, busy8, done8}); end
        repeat (2) @(negedge clk);
        checks++; if ({ld8, busy8} !== 2'b0) begin errors++; $display("[TB] FAIL mid_reset_idle: got %b expected 00", {ld8, busy8}); end
        run_op(1'b0, 8'hFF, 1'b0, dc, lc, na, ns, ee, pe, am, oc1);
        checks++; if (dc !== 26) begin errors++; $display("[TB] FAIL mid_fresh_done_cycle: got %0d expected 26", dc); end
        checks++; if (work8[15:0] !== 16'hFE01) begin errors++; $display("[TB] FAIL mid_fresh_product: got %h expected fe01", work8[15:0]); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        checks++; if (oc8 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_out_before: got %b expected 1", oc8); end
        run_op(1'b0, 8'h00, 1'b0, dc, lc, na, ns, ee, pe, am, oc1);
        checks++; if (lc !== 1)     begin errors++; $display("[TB] FAIL b2b_load_cycle: got %0d expected 1", lc); end
        checks++; if (oc1 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_out_dropped: got %b expected 0", oc1); end
        checks++; if (dc !== 18)    begin errors++; $display("[TB] FAIL b2b_done_cycle: got %0d expected 18", dc); end
    endtask

    task automatic test_n4();
        a4 = 4'hB;
        run_op(1'b1, 8'h09, 1'b0, dc, lc, na, ns, ee, pe, am, oc1);
        checks++; if (dc !== 12) begin errors++; $display("[TB] FAIL n4_done_cycle: got %0d expected 12", dc); end
        checks++; if (ns !== 4)  begin errors++; $display("[TB] FAIL n4_shifts: got %0d expected 4", ns); end
        checks++; if (na !== 2)  begin errors++; $display("[TB] FAIL n4_adds: got %0d expected 2", na); end
        checks++; if (work4[7:0] !== 8'h63) begin errors++; $display("[TB] FAIL n4_product: got %h expected 63", work4[7:0]); end
        run_op(1'b1, 8'h09, 1'b0, dc, lc, na, ns, ee, pe, am, oc1);
        checks++; if (dc !== 12)    begin errors++; $display("[TB] FAIL n4_b2b_done_cycle: got %0d expected 12", dc); end
        checks++; if (oc1 !== 1'b0) begin errors++; $display("[TB] FAIL n4_b2b_out_dropped: got %b expected 0", oc1); end
    endtask

    initial begin
        $display("[TB] starting mult_seq_ctrl bench");
        test_reset();
        test_zero();
        test_a5();
        test_ff();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        test_n4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Control FSM for the shift-add multiplier. It sits directly upstream of the datapath shifter and drives that shifter's `load_cmd`, `add_cmd`, `shift_cmd` and `out_cmd` inputs. On each iteration it samples the shifter's `lsb` to decide whether an add precedes the shift. It counts exactly `n` shifts, then holds `out_cmd` high so the shifter presents the product until the next operation starts.

## Interface
- `n`, default 8: multiplier (Q) width, i.e. the number of shift iterations; legal range is n ≥ 2.
- `CNT_W`, default `$clog2(n)`: width of the iteration counter (derived; do not override).

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begin an operation; sampled in IDLE or DONE only.
- `lsb`  in  1  bit 0 of the shifter's working register.
- `load_cmd`  out  1  load Q into the shifter and clear its upper half.
- `add_cmd`  out  1  arm the shifter's add-before-shift flag.
- `shift_cmd`  out  1  perform one right shift in the shifter.
- `out_cmd`  out  1  product-valid enable to the shifter; level-held.
- `busy`  out  1  an operation is in progress.
- `done`  out  1  one-cycle pulse when the product becomes valid.

## Operation
- States:
  - IDLE
  - LOAD
  - TEST
  - ADD
  - SHIFT
  - DONE
- Outputs are Moore-decoded from the registered state only:
  - LOAD: `load_cmd`=1
  - ADD: `add_cmd`=1
  - SHIFT: `shift_cmd`=1
  - DONE: `out_cmd`=1
  - `busy` = state ∈ {LOAD, TEST, ADD, SHIFT}
- `done`=1 only in the first cycle of DONE, via a registered entry flag.
- Transitions:
  - IDLE: `start` → LOAD; otherwise stay.
  - LOAD → TEST; iteration counter cleared to 0.
  - TEST: `lsb`=1 → ADD; `lsb`=0 → SHIFT. TEST exists because `lsb` is only valid one cycle after a load or shift.
  - ADD → SHIFT.
  - SHIFT: if counter == n-1 → DONE, else counter+1 → TEST.
  - DONE: `start` → LOAD (back-to-back operation, `out_cmd` drops); otherwise stay with `out_cmd` held.
- `start` is ignored while `busy`=1; there is no queuing.
- Counter arithmetic is unsigned in CNT_W bits. The compare is against the constant n-1, so the counter never wraps.
- Commands are mutually exclusive: at most one of `load_cmd`/`add_cmd`/`shift_cmd`/`out_cmd` is high in any cycle.

## Timing
- Reset (`rst`=1 at an edge), from any state including mid-operation:
  - next state is IDLE and the counter is 0;
  - all outputs are 0 from the following cycle.
- Reset has priority over `start`.
- Latency, with `start` sampled in cycle 0:
  - LOAD occupies cycle 1.
  - Each bit takes 2 cycles (TEST, SHIFT), or 3 cycles (TEST, ADD, SHIFT) when `lsb`=1.
  - DONE is first entered in cycle 2 + 2n + popcount(Q), which is when `done` pulses.
- Exactly n `shift_cmd` pulses and popcount(Q) `add_cmd` pulses per operation.
- Each `add_cmd` is immediately followed by `shift_cmd` in the next cycle.
- `out_cmd` rises with DONE entry. It stays high until reset or until the cycle after `start` is sampled in DONE.

## Structure
- Shared package `mult_pkg`:
  - `mult_state_t` enum {IDLE, LOAD, TEST, ADD, SHIFT, DONE};
  - `DEF_N` constant = 8.
- The shifter's own datapath widths come from the same package.
- One natural sub-module, `mult_iter_cnt`:
  - inputs: clear, increment enable;
  - output: `last` flag, asserted when count == n-1.
- FSM next-state and output decode stay in `mult_seq_ctrl`.

## Test plan
- n=8, Q=8'h00, `start` in cycle 0 → `load_cmd` in cycle 1, 8 `shift_cmd` pulses, 0 `add_cmd`; `done` in cycle 18; `out_cmd` held afterwards.
- n=8, Q=8'hA5 → `add_cmd` precedes shifts #1, #3, #6 and #8 (bits 0, 2, 5, 7); `done` in cycle 22. Checked with the shifter attached: product 8'hA5 × A.
- n=8, Q=8'hFF → 8 add/shift pairs; `done` in cycle 26; no two commands ever high together.
- `start` pulsed repeatedly while `busy` → no effect; same cycle counts as the single-start case.
- `rst` asserted during the ADD state of bit 3 → next cycle IDLE, all outputs 0. A fresh `start` then gives full nominal latency.
- `start` held in DONE → LOAD next cycle, `out_cmd` low, `done` pulses again after the second operation; repeat with n=4, Q=4'h9 → `done` in cycle 12.
